serdesphy_ana_tx_word_feeder: RTL and testbench

SERDESPHY_ANA_TX_WORD_FEEDER -- requirements
Module: serdesphy_ana_tx_word_feeder

---
 rtl/serdesphy_ana_tx_word_feeder_pkg.sv | 22 ++
 rtl/serdesphy_ana_tx_word_feeder_fifo.sv | 71 +++++++
 rtl/serdesphy_ana_tx_word_feeder.sv | 148 ++++++++++++++
 tb/tb_serdesphy_ana_tx_word_feeder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/serdesphy_ana_tx_word_feeder_pkg.sv
// Shared serdesphy TX definitions: default burst/idle words, sync burst
// length and the state encodings used by the word feeder FSMs.
package serdesphy_ana_tx_word_feeder_pkg;

    localparam int unsigned TX_WORD_W     = 16;
    localparam logic [15:0] TX_SYNC_WORD  = 16'hF0F0;
    localparam logic [15:0] TX_IDLE_WORD  = 16'hAAAA;
    localparam int unsigned TX_SYNC_COUNT = 8;

    typedef enum logic [1:0] {
        MAIN_DISABLED = 2'd0,
        MAIN_SYNC     = 2'd1,
        MAIN_RUN      = 2'd2
    } main_state_e;

    typedef enum logic [1:0] {
        HS_READY     = 2'd0,
        HS_WAIT_LOW  = 2'd1,
        HS_WAIT_HIGH = 2'd2
    } hs_state_e;

endpackage

// File: rtl/serdesphy_ana_tx_word_feeder_fifo.sv
// Single-clock word FIFO with registered occupancy; flush empties it and
// overrides any same-cycle write or read.
module serdesphy_tx_word_fifo
    import serdesphy_ana_tx_word_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = TX_WORD_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_wr, do_rd;

    always_comb begin
        full    = (level_q == DEPTH_L);
        empty   = (level_q == '0);
        level   = level_q;
        rd_data = mem_q[rd_ptr_q];
        do_wr   = wr_en && !full && !flush;
        do_rd   = rd_en && !empty && !flush;

        wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/serdesphy_ana_tx_word_feeder.sv
// TX word feeder: sends sync bursts, then FIFO words (or idle fill) to the
// serializer using a ready-low-high handshake per word.
module serdesphy_ana_tx_word_feeder
    import serdesphy_ana_tx_word_feeder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] SYNC_WORD  = TX_SYNC_WORD,
    parameter logic [15:0] IDLE_WORD  = TX_IDLE_WORD,
    parameter int unsigned SYNC_COUNT = TX_SYNC_COUNT
) (
    input  logic                        clk_240m,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        sync_req,
    input  logic                        wr_valid,
    input  logic [15:0]                 wr_data,
    output logic                        wr_ready,
    input  logic                        ser_data_ready,
    input  logic                        ser_busy,
    output logic                        ser_load,
    output logic [15:0]                 ser_parallel,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        sync_active,
    output logic                        overflow_err
);

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_COUNT - 1);

    main_state_e main_q, main_d;
    hs_state_e   hs_q, hs_d;
    logic [7:0]  sync_cnt_q, sync_cnt_d;
    logic        ser_load_q, ser_load_d;
    logic [15:0] ser_parallel_q, ser_parallel_d;
    logic        overflow_q, overflow_d;

    logic        issue, fifo_flush, fifo_wr, fifo_rd;
    logic        fifo_full, fifo_empty;
    logic [15:0] fifo_head;

    serdesphy_tx_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk_240m),
        .rst_n   (rst_n),
        .flush   (fifo_flush),
        .wr_en   (fifo_wr),
        .rd_en   (fifo_rd),
        .wr_data (wr_data),
        .rd_data (fifo_head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_240m or negedge rst_n) begin
        if (!rst_n) begin
            main_q         <= MAIN_DISABLED;
            hs_q           <= HS_READY;
            sync_cnt_q     <= '0;
            ser_load_q     <= 1'b0;
            ser_parallel_q <= '0;
            overflow_q     <= 1'b0;
        end else begin
            main_q         <= main_d;
            hs_q           <= hs_d;
            sync_cnt_q     <= sync_cnt_d;
            ser_load_q     <= ser_load_d;
            ser_parallel_q <= ser_parallel_d;
            overflow_q     <= overflow_d;
        end
    end

    always_comb begin
        main_d     = main_q;
        hs_d       = hs_q;
        sync_cnt_d = sync_cnt_q;
        if (!enable) begin
            main_d     = MAIN_DISABLED;
            hs_d       = HS_READY;
            sync_cnt_d = '0;
        end else begin
            case (main_q)
                MAIN_DISABLED: begin
                    main_d     = MAIN_SYNC;
                    sync_cnt_d = '0;
                end
                MAIN_SYNC: begin
                    if (sync_req) begin
                        sync_cnt_d = '0;
                    end else if (issue) begin
                        if (sync_cnt_q == SYNC_LAST) begin
                            main_d     = MAIN_RUN;
                            sync_cnt_d = '0;
                        end else begin
                            sync_cnt_d = sync_cnt_q + 8'd1;
                        end
                    end
                end
                MAIN_RUN: begin
                    // Outstanding word stays in ser_parallel; the next issue is a sync word.
                    if (sync_req) begin
                        main_d     = MAIN_SYNC;
                        sync_cnt_d = '0;
                    end
                end
                default: main_d = MAIN_DISABLED;
            endcase

            case (hs_q)
                HS_READY:     if (issue)           hs_d = HS_WAIT_LOW;
                HS_WAIT_LOW:  if (!ser_data_ready) hs_d = HS_WAIT_HIGH;
                HS_WAIT_HIGH: if (ser_data_ready)  hs_d = HS_READY;
                default:                           hs_d = HS_READY;
            endcase
            if (main_q == MAIN_DISABLED) hs_d = HS_READY;
        end
    end

    always_comb begin
        issue = enable && (main_q == MAIN_SYNC || main_q == MAIN_RUN) &&
                (hs_q == HS_READY) && ser_data_ready && !ser_busy;
        fifo_flush = !enable || (main_q == MAIN_DISABLED);
        wr_ready   = (main_q != MAIN_DISABLED) && !fifo_full;
        fifo_wr    = wr_valid && wr_ready;
        fifo_rd    = issue && (main_q == MAIN_RUN) && !fifo_empty;

        ser_load_d     = issue;
        ser_parallel_d = ser_parallel_q;
        if (fifo_flush) begin
            ser_parallel_d = '0;
        end else if (issue) begin
            if (main_q == MAIN_SYNC)  ser_parallel_d = SYNC_WORD;
            else if (fifo_empty)      ser_parallel_d = IDLE_WORD;
            else                      ser_parallel_d = fifo_head;
        end

        overflow_d = overflow_q;
        if (fifo_flush)                 overflow_d = 1'b0;
        else if (wr_valid && !wr_ready) overflow_d = 1'b1;

        ser_load     = ser_load_q;
        ser_parallel = ser_parallel_q;
        sync_active  = (main_q == MAIN_SYNC);
        overflow_err = overflow_q;
    end

endmodule

// File: tb/tb_serdesphy_ana_tx_word_feeder.sv
// Directed bench for the TX word feeder: a startup vector table followed by
// hand-written sequences for bursts, FIFO ordering, overflow and disable.
module tb_serdesphy_ana_tx_word_feeder;

    logic        clk_240m = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0, sync_req = 1'b0, wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic        ser_data_ready = 1'b0, ser_busy = 1'b0;
    logic        wr_ready, ser_load, sync_active, overflow_err;
    logic [15:0] ser_parallel;
    logic [2:0]  fifo_level;

    int n_vec  = 0;
    int n_miss = 0;
    int load_cnt = 0;

    serdesphy_ana_tx_word_feeder #(
        .FIFO_DEPTH (4),
        .SYNC_WORD  (16'hF0F0),
        .IDLE_WORD  (16'hAAAA),
        .SYNC_COUNT (8)
    ) dut (
        .clk_240m       (clk_240m),
        .rst_n          (rst_n),
        .enable         (enable),
        .sync_req       (sync_req),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .ser_data_ready (ser_data_ready),
        .ser_busy       (ser_busy),
        .ser_load       (ser_load),
        .ser_parallel   (ser_parallel),
        .fifo_level     (fifo_level),
        .sync_active    (sync_active),
        .overflow_err   (overflow_err)
    );

    always #5 clk_240m = ~clk_240m;

    always @(negedge clk_240m) if (rst_n && ser_load) load_cnt++;

    typedef struct {
        logic        en, sreq, wv;
        logic [15:0] wd;
        logic        sdr, busy;
        logic        e_load;
        logic [15:0] e_par;
        logic [2:0]  e_lvl;
        logic        e_wrdy, e_sync, e_ovf;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic e_load, input logic [15:0] e_par,
                           input logic [2:0] e_lvl, input logic e_wrdy,
                           input logic e_sync, input logic e_ovf);
        chk({nm, ".load"}, {15'd0, ser_load}, {15'd0, e_load});
        chk({nm, ".par"},  ser_parallel, e_par);
        chk({nm, ".lvl"},  {13'd0, fifo_level}, {13'd0, e_lvl});
        chk({nm, ".wrdy"}, {15'd0, wr_ready}, {15'd0, e_wrdy});
        chk({nm, ".sync"}, {15'd0, sync_active}, {15'd0, e_sync});
        chk({nm, ".ovf"},  {15'd0, overflow_err}, {15'd0, e_ovf});
    endtask

    task automatic cyc(input logic en, input logic sreq, input logic wv,
                       input logic [15:0] wd, input logic sdr, input logic busy);
        enable = en; sync_req = sreq; wr_valid = wv; wr_data = wd;
        ser_data_ready = sdr; ser_busy = busy;
        @(posedge clk_240m);
        #1;
    endtask

    // Serializer drops ready, raises it while busy, then accepts one word.
    task automatic serve_word(input string nm, input logic [15:0] e_par, input logic [2:0] e_lvl,
                              input logic e_sync, input logic wv, input logic [15:0] wd);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk({nm, ".pre0"}, {15'd0, ser_load}, 16'd0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk({nm, ".pre1"}, {15'd0, ser_load}, 16'd0);
        cyc(1'b1, 1'b0, wv, wd, 1'b1, 1'b0);
        chk({nm, ".load"}, {15'd0, ser_load}, 16'd1);
        chk({nm, ".par"},  ser_parallel, e_par);
        chk({nm, ".lvl"},  {13'd0, fifo_level}, {13'd0, e_lvl});
        chk({nm, ".sync"}, {15'd0, sync_active}, {15'd0, e_sync});
    endtask

    initial begin
        tbl[0] = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,3'd0,1'b0,1'b0,1'b0};
        tbl[1] = '{1'b1,1'b0,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,3'd0,1'b1,1'b1,1'b0};
        tbl[2] = '{1'b1,1'b0,1'b0,16'h0000,1'b1,1'b1, 1'b0,16'h0000,3'd0,1'b1,1'b1,1'b0};
        tbl[3] = '{1'b1,1'b0,1'b0,16'h0000,1'b1,1'b0, 1'b1,16'hF0F0,3'd0,1'b1,1'b1,1'b0};
        tbl[4] = '{1'b1,1'b0,1'b0,16'h0000,1'b1,1'b0, 1'b0,16'hF0F0,3'd0,1'b1,1'b1,1'b0};
        tbl[5] = '{1'b1,1'b0,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'hF0F0,3'd0,1'b1,1'b1,1'b0};
        tbl[6] = '{1'b1,1'b0,1'b1,16'h1234,1'b0,1'b0, 1'b0,16'hF0F0,3'd1,1'b1,1'b1,1'b0};
        tbl[7] = '{1'b1,1'b0,1'b0,16'h0000,1'b1,1'b0, 1'b0,16'hF0F0,3'd1,1'b1,1'b1,1'b0};
        tbl[8] = '{1'b1,1'b0,1'b0,16'h0000,1'b1,1'b0, 1'b1,16'hF0F0,3'd1,1'b1,1'b1,1'b0};

        repeat (2) @(posedge clk_240m);
        #1;
        chk_all("reset", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].en, tbl[i].sreq, tbl[i].wv, tbl[i].wd, tbl[i].sdr, tbl[i].busy);
            chk_all($sformatf("row%0d", i), tbl[i].e_load, tbl[i].e_par, tbl[i].e_lvl,
                    tbl[i].e_wrdy, tbl[i].e_sync, tbl[i].e_ovf);
        end

        // Remaining six words of the first burst; the last one enters RUN.
        for (int i = 0; i < 6; i++)
            serve_word($sformatf("burst%0d", i + 2), 16'hF0F0, 3'd1, (i < 5), 1'b0, 16'h0);

        cyc(1'b1, 1'b0, 1'b1, 16'h5678, 1'b0, 1'b0);
        chk("run.lvl2", {13'd0, fifo_level}, 16'd2);
        chk("burst.count", load_cnt[15:0], 16'd8);
        serve_word("run.w0", 16'h1234, 3'd1, 1'b0, 1'b0, 16'h0);
        serve_word("run.w1", 16'h5678, 3'd0, 1'b0, 1'b0, 16'h0);
        serve_word("run.idle_wr", 16'hAAAA, 3'd1, 1'b0, 1'b1, 16'h9999);
        serve_word("run.w2", 16'h9999, 3'd0, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
            chk($sformatf("hold%0d.load", i), {15'd0, ser_load}, 16'd0);
        end
        chk("hold.par", ser_parallel, 16'h9999);

        for (int k = 1; k <= 5; k++) begin
            cyc(1'b1, 1'b0, 1'b1, 16'hA000 + 16'(k), 1'b1, 1'b1);
            chk($sformatf("fill%0d.lvl", k), {13'd0, fifo_level}, (k < 4) ? 16'(k) : 16'd4);
            chk($sformatf("fill%0d.wrdy", k), {15'd0, wr_ready}, (k < 4) ? 16'd1 : 16'd0);
            chk($sformatf("fill%0d.ovf", k), {15'd0, overflow_err}, (k == 5) ? 16'd1 : 16'd0);
        end
        for (int k = 1; k <= 4; k++)
            serve_word($sformatf("drain%0d", k), 16'hA000 + 16'(k), 3'(4 - k), 1'b0, 1'b0, 16'h0);
        serve_word("drain.idle", 16'hAAAA, 3'd0, 1'b0, 1'b0, 16'h0);
        chk("drain.ovf", {15'd0, overflow_err}, 16'd1);

        cyc(1'b1, 1'b0, 1'b1, 16'hB001, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 16'hB002, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("resync.sync", {15'd0, sync_active}, 16'd1);
        chk("resync.par", ser_parallel, 16'hAAAA);
        chk("resync.lvl", {13'd0, fifo_level}, 16'd2);
        for (int i = 0; i < 8; i++)
            serve_word($sformatf("resync%0d", i), 16'hF0F0, 3'd2, (i < 7), 1'b0, 16'h0);
        serve_word("resync.q0", 16'hB001, 3'd1, 1'b0, 1'b0, 16'h0);
        serve_word("resync.q1", 16'hB002, 3'd0, 1'b0, 1'b0, 16'h0);

        for (int k = 1; k <= 3; k++)
            cyc(1'b1, 1'b0, 1'b1, 16'hC000 + 16'(k), 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk_all("predis", 1'b0, 16'hB002, 3'd3, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b0);
        chk_all("dis0", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk_all("dis1", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk_all("reen", 1'b0, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++)
            serve_word($sformatf("reburst%0d", i), 16'hF0F0, 3'd0, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("restart.sync", {15'd0, sync_active}, 16'd1);
        for (int i = 0; i < 8; i++)
            serve_word($sformatf("restart%0d", i), 16'hF0F0, 3'd0, (i < 7), 1'b0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
